// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states, reset PC and fault cause codes.
package ifu_pkg;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_OUT   = 2'd2,
        S_FAULT = 2'd3
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_ACCESS   = 2'b01;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b10;

    function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory request/response channel and decoder handoff channel.
interface ifu_fetch_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;

    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] instruction;
    logic [31:0] inst_pc;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        output inst_valid, instruction, inst_pc,
        input  inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        input  inst_valid, instruction, inst_pc,
        output inst_ready
    );

endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one outstanding imem read at a time, registered handoff to the decoder,
// PC redirect with drop tracking for in-flight responses, sticky fault reporting.
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    ifu_fetch_if.master  bus,
    input  logic         redirect_valid,
    input  logic [31:0]  redirect_pc,
    output logic         fault,
    output logic [1:0]   fault_cause,
    output logic [31:0]  fault_pc,
    output logic [31:0]  inst_count
);

    fetch_state_e state_q, state_d;
    logic         drop_q, drop_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  inst_pc_q, inst_pc_d;
    logic [31:0]  fault_pc_q, fault_pc_d;
    logic [31:0]  inst_count_q, inst_count_d;
    logic [31:0]  req_addr_q, req_addr_d;
    logic [1:0]   cause_q, cause_d;
    logic         req_valid_q, req_valid_d;
    logic         inst_valid_q, inst_valid_d;
    logic         fault_q, fault_d;

    logic req_fire;
    logic inst_fire;
    logic outstanding_now;
    logic outstanding_next;

    // Output flags are registered decodes of the next state, so they are 0 while reset is held.
    always_comb begin
        state_d      = state_q;
        drop_d       = drop_q;
        fetch_pc_d   = fetch_pc_q;
        instr_d      = instr_q;
        inst_pc_d    = inst_pc_q;
        fault_pc_d   = fault_pc_q;
        inst_count_d = inst_count_q;
        cause_d      = cause_q;

        req_fire         = req_valid_q && bus.imem_req_ready;
        inst_fire        = inst_valid_q && bus.inst_ready;
        outstanding_now  = (state_q == S_WAIT) || drop_q;
        outstanding_next = req_fire || (outstanding_now && !bus.imem_rsp_valid);

        case (state_q)
            S_REQ: begin
                if (req_fire) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.imem_rsp_valid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else if (bus.imem_rsp_err) begin
                        state_d    = S_FAULT;
                        cause_d    = CAUSE_ACCESS;
                        fault_pc_d = fetch_pc_q;
                    end else begin
                        instr_d   = bus.imem_rsp_data;
                        inst_pc_d = fetch_pc_q;
                        state_d   = S_OUT;
                    end
                end
            end
            S_OUT: begin
                if (inst_fire) begin
                    inst_count_d = inst_count_q + 32'd1;
                    fetch_pc_d   = next_seq_pc(fetch_pc_q);
                    state_d      = S_REQ;
                end
            end
            S_FAULT: begin
                if (drop_q && bus.imem_rsp_valid) begin
                    drop_d = 1'b0;
                end
            end
            default: state_d = S_REQ;
        endcase

        // Redirect overrides everything above except the instruction count on a same-cycle accept.
        if (redirect_valid) begin
            instr_d   = instr_q;
            inst_pc_d = inst_pc_q;
            drop_d    = outstanding_next;
            if (redirect_pc[1:0] != 2'b00) begin
                state_d    = S_FAULT;
                cause_d    = CAUSE_MISALIGN;
                fault_pc_d = redirect_pc;
            end else begin
                fetch_pc_d = redirect_pc;
                cause_d    = CAUSE_NONE;
                fault_pc_d = fault_pc_q;
                state_d    = outstanding_next ? S_WAIT : S_REQ;
            end
        end

        req_valid_d  = (state_d == S_REQ);
        req_addr_d   = fetch_pc_d;
        inst_valid_d = (state_d == S_OUT);
        fault_d      = (state_d == S_FAULT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_REQ;
            drop_q       <= 1'b0;
            fetch_pc_q   <= RESET_PC;
            instr_q      <= 32'd0;
            inst_pc_q    <= 32'd0;
            fault_pc_q   <= 32'd0;
            inst_count_q <= 32'd0;
            req_addr_q   <= 32'd0;
            cause_q      <= CAUSE_NONE;
            req_valid_q  <= 1'b0;
            inst_valid_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            drop_q       <= drop_d;
            fetch_pc_q   <= fetch_pc_d;
            instr_q      <= instr_d;
            inst_pc_q    <= inst_pc_d;
            fault_pc_q   <= fault_pc_d;
            inst_count_q <= inst_count_d;
            req_addr_q   <= req_addr_d;
            cause_q      <= cause_d;
            req_valid_q  <= req_valid_d;
            inst_valid_q <= inst_valid_d;
            fault_q      <= fault_d;
        end
    end

    assign bus.imem_req_valid = req_valid_q;
    assign bus.imem_req_addr  = req_addr_q;
    assign bus.inst_valid     = inst_valid_q;
    assign bus.instruction    = instr_q;
    assign bus.inst_pc        = inst_pc_q;
    assign fault              = fault_q;
    assign fault_cause        = cause_q;
    assign fault_pc           = fault_pc_q;
    assign inst_count         = inst_count_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed self-checking bench for ifu_fetch: fetch, stall, redirects, faults and reset.
module tb_ifu_fetch;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fault;
    logic [1:0]  fault_cause;
    logic [31:0] fault_pc;
    logic [31:0] inst_count;

    int testsRun;
    int testsFailed;

    ifu_fetch_if bus();

    ifu_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus.master),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fault          (fault),
        .fault_cause    (fault_cause),
        .fault_pc       (fault_pc),
        .inst_count     (inst_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %08h expected %08h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, then step past the rising edge so registered outputs can be sampled.
    task automatic applyStimulus(input logic req_ready, input logic rsp_valid, input logic [31:0] rsp_data,
                                 input logic rsp_err, input logic dec_ready,
                                 input logic redir_v, input logic [31:0] redir_pc);
        bus.imem_req_ready = req_ready;
        bus.imem_rsp_valid = rsp_valid;
        bus.imem_rsp_data  = rsp_data;
        bus.imem_rsp_err   = rsp_err;
        bus.inst_ready     = dec_ready;
        redirect_valid     = redir_v;
        redirect_pc        = redir_pc;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".req_valid"},  {31'd0, bus.imem_req_valid}, 32'd0);
        checkOutput({tag, ".req_addr"},   bus.imem_req_addr, 32'd0);
        checkOutput({tag, ".inst_valid"}, {31'd0, bus.inst_valid}, 32'd0);
        checkOutput({tag, ".instr"},      bus.instruction, 32'd0);
        checkOutput({tag, ".inst_pc"},    bus.inst_pc, 32'd0);
        checkOutput({tag, ".fault"},      {31'd0, fault}, 32'd0);
        checkOutput({tag, ".cause"},      {30'd0, fault_cause}, 32'd0);
        checkOutput({tag, ".fault_pc"},   fault_pc, 32'd0);
        checkOutput({tag, ".count"},      inst_count, 32'd0);
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst_n       = 1'b0;
        idleCycle();
        idleCycle();
        checkAllZero("reset");

        // Basic fetch at the reset PC with a one-cycle memory.
        rst_n = 1'b1;
        idleCycle();
        checkOutput("c1.req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
        checkOutput("c1.req_addr", bus.imem_req_addr, 32'h8000_0000);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        checkOutput("c2.req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
        applyStimulus(1'b0, 1'b1, 32'h0010_0093, 1'b0, 1'b0, 1'b0, 32'd0);
        checkOutput("c3.inst_valid", {31'd0, bus.inst_valid}, 32'd1);
        checkOutput("c3.instr", bus.instruction, 32'h0010_0093);
        checkOutput("c3.inst_pc", bus.inst_pc, 32'h8000_0000);

        // Decoder stall keeps outputs frozen and issues nothing.
        for (int i = 0; i < 5; i++) begin
            idleCycle();
            checkOutput("stall.instr", bus.instruction, 32'h0010_0093);
            checkOutput("stall.inst_pc", bus.inst_pc, 32'h8000_0000);
            checkOutput("stall.req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
            checkOutput("stall.count", inst_count, 32'd0);
        end
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0);
        checkOutput("acc.count", inst_count, 32'd1);
        checkOutput("acc.inst_valid", {31'd0, bus.inst_valid}, 32'd0);
        checkOutput("acc.req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
        checkOutput("acc.req_addr", bus.imem_req_addr, 32'h8000_0004);

        // Redirect while waiting; the late response must be discarded.
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h8000_0100);
        checkOutput("rw.req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
        idleCycle();
        checkOutput("rw.wait", {31'd0, bus.imem_req_valid}, 32'd0);
        applyStimulus(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 32'd0);
        checkOutput("rw.inst_valid", {31'd0, bus.inst_valid}, 32'd0);
        checkOutput("rw.req_valid2", {31'd0, bus.imem_req_valid}, 32'd1);
        checkOutput("rw.req_addr", bus.imem_req_addr, 32'h8000_0100);

        // Redirect in S_REQ without handshake just retargets the pending request.
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h8000_0008);
        checkOutput("rr.req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
        checkOutput("rr.req_addr", bus.imem_req_addr, 32'h8000_0008);

        // Access error at 8000_0008 halts fetch until a redirect.
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b1, 32'h1111_1111, 1'b1, 1'b0, 1'b0, 32'd0);
        checkOutput("err.fault", {31'd0, fault}, 32'd1);
        checkOutput("err.cause", {30'd0, fault_cause}, 32'd1);
        checkOutput("err.fault_pc", fault_pc, 32'h8000_0008);
        checkOutput("err.inst_valid", {31'd0, bus.inst_valid}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0);
            checkOutput("err.noreq", {31'd0, bus.imem_req_valid}, 32'd0);
            checkOutput("err.sticky", {31'd0, fault}, 32'd1);
        end
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h8000_0000);
        checkOutput("clr.fault", {31'd0, fault}, 32'd0);
        checkOutput("clr.cause", {30'd0, fault_cause}, 32'd0);
        checkOutput("clr.req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
        checkOutput("clr.req_addr", bus.imem_req_addr, 32'h8000_0000);

        // Misaligned redirect faults without issuing a request.
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h8000_0102);
        checkOutput("mis.fault", {31'd0, fault}, 32'd1);
        checkOutput("mis.cause", {30'd0, fault_cause}, 32'd2);
        checkOutput("mis.fault_pc", fault_pc, 32'h8000_0102);
        checkOutput("mis.req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        checkOutput("mis.noreq", {31'd0, bus.imem_req_valid}, 32'd0);

        // Redirect coincident with accept in S_OUT.
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h8000_0010);
        checkOutput("ro.req_addr", bus.imem_req_addr, 32'h8000_0010);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 32'd0);
        checkOutput("ro.inst_pc", bus.inst_pc, 32'h8000_0010);
        checkOutput("ro.instr", bus.instruction, 32'h1234_5678);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h8000_0040);
        checkOutput("ro.count", inst_count, 32'd2);
        checkOutput("ro.inst_valid", {31'd0, bus.inst_valid}, 32'd0);
        checkOutput("ro.req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
        checkOutput("ro.req_addr2", bus.imem_req_addr, 32'h8000_0040);

        // Redirect in the same cycle as the handshake: the in-flight word is dropped.
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h8000_0080);
        checkOutput("rh.req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
        applyStimulus(1'b0, 1'b1, 32'hAAAA_AAAA, 1'b0, 1'b0, 1'b0, 32'd0);
        checkOutput("rh.inst_valid", {31'd0, bus.inst_valid}, 32'd0);
        checkOutput("rh.req_valid2", {31'd0, bus.imem_req_valid}, 32'd1);
        checkOutput("rh.req_addr", bus.imem_req_addr, 32'h8000_0080);

        // Reset mid-operation returns every output to zero.
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        rst_n = 1'b0;
        idleCycle();
        checkAllZero("midreset");
        rst_n = 1'b1;
        idleCycle();
        checkOutput("rel.req_addr", bus.imem_req_addr, 32'h8000_0000);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch unit feeding the instruction decoder. Owns the PC, issues one word read at a time to instruction memory over a valid/ready request plus valid response channel, and presents each fetched 32-bit instruction with its PC to the decoder over a valid/ready handshake. Supports PC redirect from execute/branch logic, reports fetch faults, and counts instructions handed off.

## Interface
- `RESET_PC`, 32'h8000_0000: first fetch address after reset.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `imem_req_valid`  out  1  read request valid.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_req_addr`  out  32  word-aligned fetch address.
- `imem_rsp_valid`  in  1  read data valid; exactly one per accepted request.
- `imem_rsp_data`  in  32  instruction word.
- `imem_rsp_err`  in  1  access error, qualified by `imem_rsp_valid`.
- `inst_valid`  out  1  `instruction`/`inst_pc` valid to decoder.
- `inst_ready`  in  1  decoder accepts instruction.
- `instruction`  out  32  fetched word.
- `inst_pc`  out  32  address of `instruction`.
- `redirect_valid`  in  1  load new PC; one-cycle pulse.
- `redirect_pc`  in  32  target PC.
- `fault`  out  1  fetch halted on fault; sticky until redirect.
- `fault_cause`  out  2  01 access error, 10 misaligned redirect, 00 none.
- `fault_pc`  out  32  address that faulted.
- `inst_count`  out  32  instructions accepted by decoder; wraps at 2^32.

## Operation
- States: S_REQ, S_WAIT, S_OUT, S_FAULT. One outstanding request max.
- Reset: state S_REQ, `fetch_pc`=RESET_PC, drop=0. Every output 0 during reset, including `imem_req_addr`, `instruction`, `inst_pc`, `fault_pc`, `inst_count`.
- S_REQ: `imem_req_valid`=1, `imem_req_addr`=`fetch_pc`, held stable until accepted. Handshake -> S_WAIT.
- S_WAIT: on `imem_rsp_valid`: drop=1 -> discard (data and err), clear drop, -> S_REQ; err -> S_FAULT, cause 01, `fault_pc`=`fetch_pc`; else latch data and `fetch_pc` into output regs, -> S_OUT.
- S_OUT: `inst_valid`=1, outputs stable while `inst_ready`=0. Accept -> `inst_count`+1, `fetch_pc`+=4 (mod 2^32), -> S_REQ.
- S_FAULT: `fault`=1, no requests, `inst_valid`=0; left only by redirect.
- Redirect (priority over all other transitions), with `redirect_pc[1:0]`≠0: -> S_FAULT, cause 10, `fault_pc`=`redirect_pc`; drop set if a request is outstanding after this cycle. Aligned: `fetch_pc`=`redirect_pc`, clear fault/cause; then:
  - in S_REQ without handshake: stay S_REQ, new address next cycle.
  - in S_REQ with handshake same cycle: -> S_WAIT with drop=1.
  - in S_WAIT, response not this cycle: stay S_WAIT, drop=1.
  - in S_WAIT, response this cycle: response discarded, -> S_REQ.
  - in S_OUT: -> S_REQ; if `inst_ready` same cycle, the instruction counts as accepted (`inst_count`+1) but `fetch_pc`=`redirect_pc`, not +4.
  - in S_FAULT: -> S_REQ (or S_WAIT with drop if a dropped response is still pending).
- A dropped response pending while in S_FAULT or S_REQ is absorbed before any new request issues (wait in S_WAIT).

## Timing
- All outputs registered; no combinational path from any input to any output.
- Response to `inst_valid`: 1 cycle. Accept to next `imem_req_valid`: 1 cycle.
- Redirect to `imem_req_valid` at new PC: 1 cycle (no outstanding request).
- Peak throughput with zero-wait memory: 1 instruction per 3 cycles.
- Reset asserted mid-operation: next edge returns to reset state; in-flight response after reset release is memory's responsibility (memory shares `rst_n`).

## Structure
- Shared package `ifu_pkg`: state enum, `RESET_PC` default, fault cause codes (CAUSE_NONE, CAUSE_ACCESS, CAUSE_MISALIGN).
- Single module; no sub-module. Drop flag plus state register cover the in-flight tracking.

## Test plan
- Reset release, memory ready=1, one-cycle latency returning 32'h00100093: req addr 8000_0000 on cycle 1, `inst_valid` with `inst_pc`=8000_0000 on cycle 3, next req 8000_0004 one cycle after accept; `inst_count`=1.
- Decoder stalls (`inst_ready`=0 for 5 cycles): `instruction`/`inst_pc` stable, no new request, count unchanged.
- Redirect to 8000_0100 while in S_WAIT, response arrives 2 cycles later with 32'hDEADBEEF: word discarded, next req addr 8000_0100, no `inst_valid` for DEADBEEF.
- Response with `imem_rsp_err`=1 at 8000_0008: `fault`=1, cause 01, `fault_pc`=8000_0008, no requests; redirect to 8000_0000 clears fault and refetches.
- Redirect to 8000_0102: fault cause 10, `fault_pc`=8000_0102, no request issued.
- Redirect coincident with accept in S_OUT at `inst_pc`=8000_0010, target 8000_0040: count+1, next req 8000_0040.
